matriz_loader5x5: RTL

MATRIZ_LOADER5X5 -- requirements
Module: matriz_loader5x5

---
 rtl/det5_pkg.sv | 7 +
 rtl/matriz_loader5x5.sv | 68 ++++++
 2 files changed

// File: rtl/det5_pkg.sv
// det5_pkg: shared sizing and FSM encoding for the 5x5 matrix loader and determinant stage.
package det5_pkg;
  localparam int W = 8;
  localparam int N = 5;
  localparam int MAT_W = N * N * W;
  typedef enum logic [1:0] {LOAD, RUN, RESULT, GAP} state_t;
endpackage

// File: rtl/matriz_loader5x5.sv
// matriz_loader5x5: loads an NxN matrix row-major, runs the determinant stage, holds its result until acked.
module matriz_loader5x5 #(
  parameter int W = 8,
  parameter int N = 5,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [N*N*W-1:0] matriz_A,
  output logic             start,
  input  logic             done,
  input  logic [W-1:0]     det,
  output logic [W-1:0]     res_det,
  output logic             res_valid,
  input  logic             res_ack,
  output logic             err,
  output logic             busy
);
  import det5_pkg::*;
  localparam int NN = N * N;
  localparam int IW = $clog2(NN);
  state_t state;
  logic [IW-1:0] idx;
  logic [31:0] cnt;
  logic expired;
  assign in_ready = state == LOAD;
  assign busy = state != LOAD;
  assign expired = cnt == 32'(TIMEOUT - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= LOAD;
      idx <= '0;
      cnt <= '0;
      matriz_A <= '0;
      start <= 1'b0;
      res_det <= '0;
      res_valid <= 1'b0;
      err <= 1'b0;
    end else begin
      case (state)
        LOAD: if (in_valid) begin
          matriz_A[int'(idx) * W +: W] <= in_data;
          idx <= idx == IW'(NN - 1) ? '0 : idx + IW'(1);
          if (idx == IW'(NN - 1)) begin
            cnt <= '0;
            start <= 1'b1;
            state <= RUN;
          end
        end
        // done takes priority over an expiring counter on the same cycle
        RUN: if (done || expired) begin
          res_det <= done ? det : '0;
          err <= !done;
          res_valid <= 1'b1;
          start <= 1'b0;
          state <= RESULT;
        end else cnt <= cnt + 32'd1;
        RESULT: if (res_ack) begin
          res_valid <= 1'b0;
          state <= GAP;
        end
        default: state <= LOAD;
      endcase
    end
endmodule
